trajectory_predictor: RTL and testbench
=======================================

Name: trajectory_predictor

Overview:
Parametrised successor to the single-paddle collision predictor. Estimates ball velocity from two successive frame samples, then steps the trajectory one frame-step per clock with top/bottom wall reflection until the ball reaches the paddle plane it is heading for. Serves both paddles, handles arbitrary dx/dy, and reports the predicted y, the arrival direction, the bounce count and a timeout. Feeds the AI paddle controller.

Parameters:
COORD_W, 10, coordinate width in bits
V_RES, 480, visible lines
BALL_SIZE, 8, ball height and width in pixels
LEFT_PADDLE_X, 16, x of the left paddle face; the ball's left edge arrives when x <= this
RIGHT_PADDLE_X, 624, x of the right paddle face; the ball arrives when x >= RIGHT_PADDLE_X-BALL_SIZE
MAX_STEPS, 1023, simulation step limit before timeout

Ports:
clock_in  in  1  system clock
reset_n_in  in  1  asynchronous, active-low reset
vsync_start_in  in  1  one-cycle frame strobe; samples the ball position
ball_x_in  in  COORD_W  current ball x (left edge)
ball_y_in  in  COORD_W  current ball y (top edge)
predicted_valid_out  out  1  prediction is held valid
predicted_y_out  out  COORD_W  predicted ball y at the paddle plane
predicted_side_out  out  1  0 = left paddle, 1 = right paddle
arrive_up_out  out  1  ball is moving up on arrival
bounce_count_out  out  4  wall reflections, saturating at 15
busy_out  out  1  simulation in progress
timeout_out  out  1  one-cycle pulse when MAX_STEPS is exceeded

Behaviour:
- Clock and reset: single clock domain on clock_in. reset_n_in is asynchronous and active-low.
- Reset values:
  - valid, busy, timeout, side, arrive_up and bounce_count are all 0.
  - predicted_y = (V_RES-BALL_SIZE)/2.
  - The sample registers are cleared and have_sample = 0.
- Sampling: on vsync_start_in, prev <= cur and cur <= (ball_x_in, ball_y_in); have_sample <= 1 after the first sample. There is no zero-coordinate guard.
- Velocity: dx = cur_x - prev_x and dy = cur_y - prev_y, both signed COORD_W+1. Velocity is valid only after two samples.
- Sim arithmetic: sim_x and sim_y are signed COORD_W+2, so there is no wrap.
- States: IDLE, LAUNCH, SIM, DONE.
  - IDLE: on the cycle after vsync_start_in, with two samples and dx != 0, go to LAUNCH.
  - LAUNCH (1 cycle):
    - Latch dir = sign(dx), vx = dx, vy = dy and sim = cur; clear steps and bounces.
    - side = (dx > 0); target = LEFT_PADDLE_X or RIGHT_PADDLE_X-BALL_SIZE.
    - Go to SIM.
  - SIM (one step per clock):
    - nx = sim_x+vx; ny = sim_y+vy.
    - If ny < 0: ny = -ny, vy = -vy, bounces++.
    - Else if ny > V_RES-BALL_SIZE: ny = 2*(V_RES-BALL_SIZE)-ny, vy = -vy, bounces++.
    - Arrival: (dir left & nx <= target) or (dir right & nx >= target). On arrival, register predicted_y = ny clamped to [0, V_RES-BALL_SIZE], arrive_up = (vy < 0) after the fold, bounce_count; go to DONE.
    - No sub-step interpolation: the result is quantised to whole frame steps.
    - If steps == MAX_STEPS before arrival: pulse timeout_out and go to IDLE with valid = 0.
  - DONE:
    - valid = 1; outputs are frozen.
    - A new velocity with sign(dx) != dir, or dx == 0 (paddle hit or serve), drops valid on the next cycle and returns to IDLE. IDLE then relaunches on the next qualifying frame.
- busy_out = (state == LAUNCH or SIM).
- Latency: N arrival steps give valid at N+2 clock edges after the edge that samples vsync_start_in.
- Simultaneous events: vsync during SIM updates the sample registers only; the simulation keeps its latched velocity. A direction reversal seen during SIM aborts to IDLE without valid.
- Reset mid-operation: all state returns to reset values immediately. Two fresh samples are required before the next launch.
- Bounce count saturates at 15 and never wraps.

Decomposition:
- defines.vh: V_RES/BALL_SIZE defaults and paddle-x defaults, alongside the existing video constants.
- State encodings: local parameters.
- Sub-module trajectory_step: combinational one-step advance plus reflection fold. Inputs sim_x, sim_y, vx, vy; outputs nx, ny, vy_next, bounced. Reusable by the serve logic.

Test Plan:
- Defaults; vsync samples (300,200) then (296,204) -> 70 steps; valid at edge 72; predicted_y = 460, side = 0, arrive_up = 1, bounce_count = 1.
- Samples (100,100) then (104,102) -> 128 steps; predicted_y = 358, side = 1, arrive_up = 0, bounce_count = 0.
- Samples (200,50) then (200,54) (dx = 0) -> no launch; busy and valid stay 0 across 10 frames.
- After DONE of scenario 1, sample (292,208) then (296,204) (dx = +4) -> valid drops next cycle; relaunch toward the right; side = 1.
- MAX_STEPS = 16 with scenario 1 -> timeout_out high for exactly 1 cycle; valid stays 0; state returns to IDLE.
- Assert reset_n_in low mid-SIM (step 30) -> all outputs at reset values asynchronously, predicted_y = 236. After release, one sample gives no launch; the second sample launches.

Source files
------------

// File: rtl/trajectory_predictor_pkg.sv
// Shared types, default geometry and helpers for the ball trajectory predictor.
// Defaults follow the 640x480 playfield with an 8-pixel ball.
package trajectory_predictor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_SIM    = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int DEF_COORD_W        = 10;
    localparam int DEF_V_RES          = 480;
    localparam int DEF_BALL_SIZE      = 8;
    localparam int DEF_LEFT_PADDLE_X  = 16;
    localparam int DEF_RIGHT_PADDLE_X = 624;
    localparam int DEF_MAX_STEPS      = 1023;

    localparam logic [3:0] BOUNCE_MAX = 4'd15;

    // Wall-bounce counter increment that sticks at its maximum instead of wrapping.
    function automatic logic [3:0] satInc(input logic [3:0] value);
        return (value == BOUNCE_MAX) ? value : value + 4'd1;
    endfunction

endpackage

// File: rtl/trajectory_predictor_step.sv
// Combinational single frame-step advance of the ball, with top/bottom wall reflection.
// Usable anywhere a ball position has to be projected one frame ahead.
module trajectory_predictor_step
    import trajectory_predictor_pkg::*;
#(
    parameter int SIM_W     = DEF_COORD_W + 2,
    parameter int VEL_W     = DEF_COORD_W + 1,
    parameter int V_RES     = DEF_V_RES,
    parameter int BALL_SIZE = DEF_BALL_SIZE
) (
    input  logic signed [SIM_W-1:0] i_simX,
    input  logic signed [SIM_W-1:0] i_simY,
    input  logic signed [VEL_W-1:0] i_vx,
    input  logic signed [VEL_W-1:0] i_vy,
    output logic signed [SIM_W-1:0] o_nx,
    output logic signed [SIM_W-1:0] o_ny,
    output logic signed [VEL_W-1:0] o_vyNext,
    output logic                    o_bounced
);
    localparam logic signed [SIM_W-1:0] Y_LIMIT = SIM_W'(V_RES - BALL_SIZE);
    localparam logic signed [SIM_W-1:0] Y_FOLD  = SIM_W'(2 * (V_RES - BALL_SIZE));

    logic signed [SIM_W-1:0] w_vxExt;
    logic signed [SIM_W-1:0] w_vyExt;
    logic signed [SIM_W-1:0] w_rawY;

    assign w_vxExt = {{(SIM_W-VEL_W){i_vx[VEL_W-1]}}, i_vx};
    assign w_vyExt = {{(SIM_W-VEL_W){i_vy[VEL_W-1]}}, i_vy};
    assign w_rawY  = i_simY + w_vyExt;

    // A step that lands past a wall is mirrored back about that wall.
    always_comb begin
        o_nx      = i_simX + w_vxExt;
        o_ny      = w_rawY;
        o_vyNext  = i_vy;
        o_bounced = 1'b0;
        if (w_rawY[SIM_W-1]) begin
            o_ny      = -w_rawY;
            o_vyNext  = -i_vy;
            o_bounced = 1'b1;
        end else if (w_rawY > Y_LIMIT) begin
            o_ny      = Y_FOLD - w_rawY;
            o_vyNext  = -i_vy;
            o_bounced = 1'b1;
        end
    end

endmodule

// File: rtl/trajectory_predictor.sv
// Ball trajectory predictor: estimates velocity from two frame samples, then walks the path
// one frame-step per clock, folding at the walls, until the ball reaches a paddle plane.
module trajectory_predictor
    import trajectory_predictor_pkg::*;
#(
    parameter int COORD_W        = DEF_COORD_W,
    parameter int V_RES          = DEF_V_RES,
    parameter int BALL_SIZE      = DEF_BALL_SIZE,
    parameter int LEFT_PADDLE_X  = DEF_LEFT_PADDLE_X,
    parameter int RIGHT_PADDLE_X = DEF_RIGHT_PADDLE_X,
    parameter int MAX_STEPS      = DEF_MAX_STEPS
) (
    input  logic               clock_in,
    input  logic               reset_n_in,
    input  logic               vsync_start_in,
    input  logic [COORD_W-1:0] ball_x_in,
    input  logic [COORD_W-1:0] ball_y_in,
    output logic               predicted_valid_out,
    output logic [COORD_W-1:0] predicted_y_out,
    output logic               predicted_side_out,
    output logic               arrive_up_out,
    output logic [3:0]         bounce_count_out,
    output logic               busy_out,
    output logic               timeout_out
);
    localparam int SIM_W  = COORD_W + 2;
    localparam int VEL_W  = COORD_W + 1;
    localparam int STEP_W = $clog2(MAX_STEPS + 1);

    localparam logic signed [SIM_W-1:0] TGT_LEFT  = SIM_W'(LEFT_PADDLE_X);
    localparam logic signed [SIM_W-1:0] TGT_RIGHT = SIM_W'(RIGHT_PADDLE_X - BALL_SIZE);
    localparam logic signed [SIM_W-1:0] Y_LIMIT   = SIM_W'(V_RES - BALL_SIZE);
    localparam logic [COORD_W-1:0]      Y_LIMIT_C = COORD_W'(V_RES - BALL_SIZE);
    localparam logic [COORD_W-1:0]      Y_CENTRE  = COORD_W'((V_RES - BALL_SIZE) / 2);
    localparam logic [STEP_W-1:0]       STEP_LIM  = STEP_W'(MAX_STEPS);

    state_t r_state;
    state_t w_nextState;

    logic [COORD_W-1:0] r_curX;
    logic [COORD_W-1:0] r_curY;
    logic [COORD_W-1:0] r_prevX;
    logic [COORD_W-1:0] r_prevY;
    logic               r_haveSample;
    logic               r_haveTwo;
    logic               r_vsyncDly;

    logic signed [VEL_W-1:0] w_dx;
    logic signed [VEL_W-1:0] w_dy;
    logic                    w_newFrame;
    logic                    w_dxZero;
    logic                    w_dxRight;

    logic                    r_dirRight;
    logic signed [VEL_W-1:0] r_vx;
    logic signed [VEL_W-1:0] r_vy;
    logic signed [SIM_W-1:0] r_simX;
    logic signed [SIM_W-1:0] r_simY;
    logic signed [SIM_W-1:0] r_target;
    logic [STEP_W-1:0]       r_steps;
    logic [3:0]              r_bounces;

    logic signed [SIM_W-1:0] w_nx;
    logic signed [SIM_W-1:0] w_ny;
    logic signed [VEL_W-1:0] w_vyNext;
    logic                    w_bounced;
    logic                    w_arrive;
    logic                    w_timeoutHit;
    logic                    w_advance;
    logic [3:0]              w_bouncesNext;
    logic [COORD_W-1:0]      w_clampedY;

    logic [COORD_W-1:0] r_predY;
    logic               r_side;
    logic               r_arriveUp;
    logic [3:0]         r_bounceOut;
    logic               r_timeout;

    // Frame sampler: keeps the last two ball positions; velocity is trusted only after two samples.
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_curX       <= '0;
            r_curY       <= '0;
            r_prevX      <= '0;
            r_prevY      <= '0;
            r_haveSample <= 1'b0;
            r_haveTwo    <= 1'b0;
            r_vsyncDly   <= 1'b0;
        end else begin
            r_vsyncDly <= vsync_start_in;
            if (vsync_start_in) begin
                r_prevX      <= r_curX;
                r_prevY      <= r_curY;
                r_curX       <= ball_x_in;
                r_curY       <= ball_y_in;
                r_haveSample <= 1'b1;
                r_haveTwo    <= r_haveSample;
            end
        end
    end

    assign w_dx       = $signed({1'b0, r_curX}) - $signed({1'b0, r_prevX});
    assign w_dy       = $signed({1'b0, r_curY}) - $signed({1'b0, r_prevY});
    assign w_newFrame = r_vsyncDly & r_haveTwo;
    assign w_dxZero   = (w_dx == '0);
    assign w_dxRight  = ~w_dx[VEL_W-1] & ~w_dxZero;

    trajectory_predictor_step #(
        .SIM_W     (SIM_W),
        .VEL_W     (VEL_W),
        .V_RES     (V_RES),
        .BALL_SIZE (BALL_SIZE)
    ) u_step (
        .i_simX    (r_simX),
        .i_simY    (r_simY),
        .i_vx      (r_vx),
        .i_vy      (r_vy),
        .o_nx      (w_nx),
        .o_ny      (w_ny),
        .o_vyNext  (w_vyNext),
        .o_bounced (w_bounced)
    );

    assign w_arrive      = r_dirRight ? (w_nx >= r_target) : (w_nx <= r_target);
    assign w_bouncesNext = w_bounced ? satInc(r_bounces) : r_bounces;

    always_comb begin
        w_clampedY = w_ny[COORD_W-1:0];
        if (w_ny[SIM_W-1]) begin
            w_clampedY = '0;
        end else if (w_ny > Y_LIMIT) begin
            w_clampedY = Y_LIMIT_C;
        end
    end

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // A reversal during SIM abandons the run; in DONE a zero dx also counts as the rally ending.
    always_comb begin
        w_nextState  = r_state;
        w_timeoutHit = 1'b0;
        w_advance    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_newFrame && !w_dxZero) begin
                    w_nextState = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                w_nextState = ST_SIM;
            end
            ST_SIM: begin
                if (w_newFrame && !w_dxZero && (w_dxRight != r_dirRight)) begin
                    w_nextState = ST_IDLE;
                end else if (r_steps == STEP_LIM) begin
                    w_timeoutHit = 1'b1;
                    w_nextState  = ST_IDLE;
                end else begin
                    w_advance = 1'b1;
                    if (w_arrive) begin
                        w_nextState = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (w_newFrame && (w_dxZero || (w_dxRight != r_dirRight))) begin
                    w_nextState = ST_IDLE;
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_dirRight  <= 1'b0;
            r_vx        <= '0;
            r_vy        <= '0;
            r_simX      <= '0;
            r_simY      <= '0;
            r_target    <= '0;
            r_steps     <= '0;
            r_bounces   <= '0;
            r_predY     <= Y_CENTRE;
            r_side      <= 1'b0;
            r_arriveUp  <= 1'b0;
            r_bounceOut <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_timeout <= w_timeoutHit;
            if (r_state == ST_LAUNCH) begin
                r_dirRight <= w_dxRight;
                r_vx       <= w_dx;
                r_vy       <= w_dy;
                r_simX     <= $signed({2'b00, r_curX});
                r_simY     <= $signed({2'b00, r_curY});
                r_target   <= w_dxRight ? TGT_RIGHT : TGT_LEFT;
                r_steps    <= '0;
                r_bounces  <= '0;
                r_side     <= w_dxRight;
            end else if (w_advance) begin
                r_simX    <= w_nx;
                r_simY    <= w_ny;
                r_vy      <= w_vyNext;
                r_steps   <= r_steps + 1'b1;
                r_bounces <= w_bouncesNext;
                if (w_arrive) begin
                    r_predY     <= w_clampedY;
                    r_arriveUp  <= w_vyNext[VEL_W-1];
                    r_bounceOut <= w_bouncesNext;
                end
            end
        end
    end

    assign predicted_valid_out = (r_state == ST_DONE);
    assign busy_out            = (r_state == ST_LAUNCH) || (r_state == ST_SIM);
    assign predicted_y_out     = r_predY;
    assign predicted_side_out  = r_side;
    assign arrive_up_out       = r_arriveUp;
    assign bounce_count_out    = r_bounceOut;
    assign timeout_out         = r_timeout;

endmodule

// File: tb/tb_trajectory_predictor.sv
// Bench for trajectory_predictor: fixed vector table, randomized flights against a
// plain-arithmetic flight model, and hand sequences for exit, timeout and reset cases.
module tb_trajectory_predictor;

    localparam int YMAX      = 472;
    localparam int LEFT_T    = 16;
    localparam int RIGHT_T   = 616;
    localparam int MAXS      = 1023;
    localparam int MAXS_B    = 16;
    localparam int Y_CENTRE  = 236;

    logic       clock  = 1'b0;
    logic       resetN = 1'b1;
    logic       vsync  = 1'b0;
    logic [9:0] ballX  = 10'd0;
    logic [9:0] ballY  = 10'd0;

    logic       validA, sideA, upA, busyA, timeoutA;
    logic [9:0] predYA;
    logic [3:0] bouncesA;
    logic       validB, sideB, upB, busyB, timeoutB;
    logic [9:0] predYB;
    logic [3:0] bouncesB;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int px, py, cx, cy;
        int steps, y, side, up, bounces;
    } vec_t;

    vec_t vectors[$];

    always #5 clock = ~clock;

    trajectory_predictor dutA (
        .clock_in            (clock),
        .reset_n_in          (resetN),
        .vsync_start_in      (vsync),
        .ball_x_in           (ballX),
        .ball_y_in           (ballY),
        .predicted_valid_out (validA),
        .predicted_y_out     (predYA),
        .predicted_side_out  (sideA),
        .arrive_up_out       (upA),
        .bounce_count_out    (bouncesA),
        .busy_out            (busyA),
        .timeout_out         (timeoutA)
    );

    trajectory_predictor #(.MAX_STEPS(MAXS_B)) dutB (
        .clock_in            (clock),
        .reset_n_in          (resetN),
        .vsync_start_in      (vsync),
        .ball_x_in           (ballX),
        .ball_y_in           (ballY),
        .predicted_valid_out (validB),
        .predicted_y_out     (predYB),
        .predicted_side_out  (sideB),
        .arrive_up_out       (upB),
        .bounce_count_out    (bouncesB),
        .busy_out            (busyB),
        .timeout_out         (timeoutB)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Flight model: straight-line frame steps, mirror at the walls, stop at the paddle plane.
    function automatic void predictModel(input int px, input int py, input int cx, input int cy,
                                         input int maxSteps, output int steps, output int y,
                                         output int side, output int up, output int bounces,
                                         output bit timedOut);
        int vx;
        int vy;
        int x;
        int tgt;
        vx = cx - px;
        vy = cy - py;
        x = cx;
        y = cy;
        side = (vx > 0) ? 1 : 0;
        tgt = (vx > 0) ? RIGHT_T : LEFT_T;
        steps = 0;
        bounces = 0;
        up = 0;
        timedOut = 1'b0;
        while (1) begin
            if (steps == maxSteps) begin
                timedOut = 1'b1;
                return;
            end
            x += vx;
            y += vy;
            steps++;
            if (y < 0) begin
                y = -y;
                vy = -vy;
                bounces++;
            end else if (y > YMAX) begin
                y = 2 * YMAX - y;
                vy = -vy;
                bounces++;
            end
            if ((vx > 0 && x >= tgt) || (vx < 0 && x <= tgt)) break;
        end
        if (bounces > 15) bounces = 15;
        if (y < 0) y = 0;
        else if (y > YMAX) y = YMAX;
        up = (vy < 0) ? 1 : 0;
    endfunction

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic applyStimulus(input int x, input int y);
        @(negedge clock);
        vsync = 1'b1;
        ballX = 10'(x);
        ballY = 10'(y);
        @(negedge clock);
        vsync = 1'b0;
    endtask

    task automatic doReset();
        @(negedge clock);
        vsync  = 1'b0;
        resetN = 1'b0;
        waitCycles(2);
        resetN = 1'b1;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " valid"}, int'(validA), 0);
        checkOutput({tag, " busy"}, int'(busyA), 0);
        checkOutput({tag, " predY"}, int'(predYA), Y_CENTRE);
        checkOutput({tag, " side"}, int'(sideA), 0);
        checkOutput({tag, " up"}, int'(upA), 0);
        checkOutput({tag, " bounces"}, int'(bouncesA), 0);
        checkOutput({tag, " timeout"}, int'(timeoutA), 0);
    endtask

    // Called right after the launching frame: valid must appear exactly steps+2 edges later.
    task automatic checkLaunch(input string tag, input int steps, input int y, input int side,
                               input int up, input int bounces);
        waitCycles(steps + 1);
        checkOutput({tag, " busy before arrival"}, int'(busyA), 1);
        checkOutput({tag, " valid before arrival"}, int'(validA), 0);
        waitCycles(1);
        checkOutput({tag, " valid"}, int'(validA), 1);
        checkOutput({tag, " busy after"}, int'(busyA), 0);
        checkOutput({tag, " predY"}, int'(predYA), y);
        checkOutput({tag, " side"}, int'(sideA), side);
        checkOutput({tag, " up"}, int'(upA), up);
        checkOutput({tag, " bounces"}, int'(bouncesA), bounces);
    endtask

    initial begin
        #4_000_000;
        errors++;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int steps, y, side, up, b;
        bit to;
        int vx, vy, cx, cy;
        int pulses;
        logic seenBusy, seenValid;

        vectors.push_back('{300, 200, 296, 204, 70, 460, 0, 1, 1});
        vectors.push_back('{100, 100, 104, 102, 128, 358, 1, 0, 0});
        vectors.push_back('{400, 10, 390, 4, 38, 224, 0, 0, 1});
        vectors.push_back('{600, 100, 610, 100, 1, 100, 1, 0, 0});
        vectors.push_back('{24, 300, 20, 300, 1, 300, 0, 0, 0});
        vectors.push_back('{612, 0, 614, 0, 1, 0, 1, 0, 0});
        vectors.push_back('{300, 464, 296, 468, 70, 196, 0, 1, 1});
        vectors.push_back('{600, 0, 599, 236, 583, 0, 0, 1, 15});

        #2 resetN = 1'b0;
        #1 checkResetValues("initial reset");
        waitCycles(2);
        resetN = 1'b1;

        foreach (vectors[i]) begin
            doReset();
            applyStimulus(vectors[i].px, vectors[i].py);
            waitCycles(3);
            checkOutput($sformatf("vec%0d single sample busy", i), int'(busyA), 0);
            applyStimulus(vectors[i].cx, vectors[i].cy);
            checkLaunch($sformatf("vec%0d", i), vectors[i].steps, vectors[i].y,
                        vectors[i].side, vectors[i].up, vectors[i].bounces);
        end

        for (int n = 0; n < 16; n++) begin
            vx = int'($urandom_range(1, 12));
            if ($urandom_range(0, 1) == 1) vx = -vx;
            vy = int'($urandom_range(0, 24)) - 12;
            cx = int'($urandom_range(40, 600));
            cy = int'($urandom_range(12, 460));
            predictModel(cx - vx, cy - vy, cx, cy, MAXS, steps, y, side, up, b, to);
            doReset();
            applyStimulus(cx - vx, cy - vy);
            applyStimulus(cx, cy);
            checkLaunch($sformatf("rand%0d", n), steps, y, side, up, b);
        end

        doReset();
        applyStimulus(200, 50);
        applyStimulus(200, 54);
        seenBusy = 1'b0;
        seenValid = 1'b0;
        for (int f = 0; f < 10; f++) begin
            applyStimulus(200, 58 + 4 * f);
            for (int c = 0; c < 4; c++) begin
                waitCycles(1);
                seenBusy  = seenBusy | busyA;
                seenValid = seenValid | validA;
            end
        end
        checkOutput("dx0 busy seen", int'(seenBusy), 0);
        checkOutput("dx0 valid seen", int'(seenValid), 0);

        doReset();
        applyStimulus(300, 200);
        applyStimulus(296, 204);
        checkLaunch("exit base", 70, 460, 0, 1, 1);
        waitCycles(3);
        applyStimulus(292, 208);
        waitCycles(3);
        checkOutput("same dir keeps valid", int'(validA), 1);
        checkOutput("same dir frozen predY", int'(predYA), 460);
        applyStimulus(296, 204);
        checkOutput("reversal valid held one cycle", int'(validA), 1);
        waitCycles(1);
        checkOutput("reversal valid dropped", int'(validA), 0);
        checkOutput("reversal busy", int'(busyA), 0);
        predictModel(296, 204, 300, 204, MAXS, steps, y, side, up, b, to);
        applyStimulus(300, 204);
        checkLaunch("relaunch right", steps, y, side, up, b);

        applyStimulus(300, 200);
        waitCycles(3);
        checkOutput("dx0 exits done", int'(validA), 0);
        applyStimulus(296, 204);
        waitCycles(32);
        checkOutput("mid sim busy", int'(busyA), 1);
        resetN = 1'b0;
        #1 checkResetValues("mid sim reset");
        @(negedge clock);
        resetN = 1'b1;
        applyStimulus(300, 200);
        seenBusy = 1'b0;
        for (int c = 0; c < 5; c++) begin
            waitCycles(1);
            seenBusy = seenBusy | busyA | validA;
        end
        checkOutput("post reset single sample launch", int'(seenBusy), 0);
        applyStimulus(296, 204);
        checkLaunch("post reset", 70, 460, 0, 1, 1);

        predictModel(300, 200, 296, 204, MAXS_B, steps, y, side, up, b, to);
        doReset();
        applyStimulus(300, 200);
        applyStimulus(296, 204);
        pulses = 0;
        seenValid = 1'b0;
        for (int c = 0; c < 40; c++) begin
            waitCycles(1);
            if (timeoutB) pulses++;
            seenValid = seenValid | validB;
        end
        checkOutput("timeout pulse cycles", pulses, to ? 1 : 0);
        checkOutput("timeout valid seen", int'(seenValid), 0);
        checkOutput("timeout busy after", int'(busyB), 0);
        checkOutput("long limit no timeout", int'(timeoutA), 0);

        predictModel(84, 200, 80, 200, MAXS_B, steps, y, side, up, b, to);
        doReset();
        applyStimulus(84, 200);
        applyStimulus(80, 200);
        pulses = 0;
        for (int c = 0; c < steps + 1; c++) begin
            waitCycles(1);
            if (timeoutB) pulses++;
        end
        checkOutput("limit edge valid early", int'(validB), 0);
        waitCycles(1);
        checkOutput("limit edge valid", int'(validB), to ? 0 : 1);
        checkOutput("limit edge predY", int'(predYB), y);
        checkOutput("limit edge timeout pulses", pulses, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
